// File: rtl/chime_driver.sv
// Turns rising edges of the hourly-chime and alarm levels into timed
// square-wave beep sequences on a piezo pin; alarm preempts the chime.
module chime_driver #(
  parameter int unsigned BEEP_CYC     = 25000000,
  parameter int unsigned GAP_CYC      = 25000000,
  parameter int unsigned HP_HOURLY    = 62500,
  parameter int unsigned HP_ALARM     = 31250,
  parameter int unsigned HOURLY_BEEPS = 3,
  parameter int unsigned ALARM_BEEPS  = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       hourly_req,
  input  logic       alarm_req,
  input  logic       stop,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic       src_alarm,
  output logic [3:0] beep_idx,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;

  state_t      state;
  logic        buzzer_raw;
  logic        hourly_d;
  logic        alarm_d;
  logic [31:0] tone_cnt;
  logic [31:0] dur_cnt;

  logic        hr_edge;
  logic        al_edge;
  logic [31:0] hp_sel;
  logic [3:0]  last_idx;

  assign hr_edge  = hourly_req & ~hourly_d;
  assign al_edge  = alarm_req & ~alarm_d;
  assign hp_sel   = src_alarm ? HP_ALARM : HP_HOURLY;
  assign last_idx = src_alarm ? 4'(ALARM_BEEPS - 1) : 4'(HOURLY_BEEPS - 1);

  // buzzer is updated alongside buzzer_raw so mute adds no latency
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      buzzer_raw <= 1'b0;
      buzzer     <= 1'b0;
      busy       <= 1'b0;
      src_alarm  <= 1'b0;
      done       <= 1'b0;
      beep_idx   <= 4'd0;
      tone_cnt   <= 32'd0;
      dur_cnt    <= 32'd0;
      hourly_d   <= 1'b1;
      alarm_d    <= 1'b1;
    end else begin
      hourly_d <= hourly_req;
      alarm_d  <= alarm_req;
      done     <= 1'b0;
      buzzer   <= buzzer_raw & ~mute;
      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        buzzer_raw <= 1'b0;
        buzzer     <= 1'b0;
        tone_cnt   <= 32'd0;
        dur_cnt    <= 32'd0;
        beep_idx   <= 4'd0;
      end else if (al_edge || (hr_edge && state == IDLE)) begin
        state      <= BEEP;
        busy       <= 1'b1;
        buzzer_raw <= 1'b1;
        buzzer     <= ~mute;
        tone_cnt   <= 32'd0;
        dur_cnt    <= 32'd0;
        beep_idx   <= 4'd0;
        src_alarm  <= al_edge;
      end else begin
        case (state)
          BEEP: begin
            if (dur_cnt == BEEP_CYC - 1) begin
              state      <= GAP;
              buzzer_raw <= 1'b0;
              buzzer     <= 1'b0;
              dur_cnt    <= 32'd0;
            end else begin
              dur_cnt <= dur_cnt + 32'd1;
              if (tone_cnt == hp_sel - 1) begin
                tone_cnt   <= 32'd0;
                buzzer_raw <= ~buzzer_raw;
                buzzer     <= ~buzzer_raw & ~mute;
              end else begin
                tone_cnt <= tone_cnt + 32'd1;
              end
            end
          end
          GAP: begin
            if (dur_cnt == GAP_CYC - 1) begin
              dur_cnt <= 32'd0;
              if (beep_idx == last_idx) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state      <= BEEP;
                beep_idx   <= beep_idx + 4'd1;
                buzzer_raw <= 1'b1;
                buzzer     <= ~mute;
                tone_cnt   <= 32'd0;
              end
            end else begin
              dur_cnt <= dur_cnt + 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chime_driver.sv
// Self-checking bench for chime_driver with small timing parameters and a
// timeline-based reference model of each beep sequence.
module tb_chime_driver;

  localparam int BEEP = 20;
  localparam int GAP  = 10;
  localparam int HPH  = 2;
  localparam int HPA  = 1;
  localparam int NH   = 3;
  localparam int NA   = 4;
  localparam int PER  = BEEP + GAP;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       hourly_req = 1'b0;
  logic       alarm_req = 1'b0;
  logic       stop = 1'b0;
  logic       mute = 1'b0;
  logic       buzzer;
  logic       busy;
  logic       src_alarm;
  logic [3:0] beep_idx;
  logic       done;

  int total = 0;
  int bad   = 0;

  chime_driver #(
    .BEEP_CYC(BEEP), .GAP_CYC(GAP), .HP_HOURLY(HPH), .HP_ALARM(HPA),
    .HOURLY_BEEPS(NH), .ALARM_BEEPS(NA)
  ) dut (
    .clk(clk), .clr(clr), .hourly_req(hourly_req), .alarm_req(alarm_req),
    .stop(stop), .mute(mute), .buzzer(buzzer), .busy(busy),
    .src_alarm(src_alarm), .beep_idx(beep_idx), .done(done)
  );

  always #5 clk = ~clk;

  // Expected {busy, buzzer, src_alarm, done, beep_idx} t cycles after a start.
  function automatic logic [7:0] model(int t, bit al, bit mu);
    int n, hp, len, pos;
    logic [7:0] r;
    n   = al ? NA : NH;
    hp  = al ? HPA : HPH;
    len = n * PER;
    if (t < len) begin
      pos = t % PER;
      r = {1'b1, ((pos < BEEP) && (((pos / hp) % 2) == 0) && !mu), al, 1'b0, 4'(t / PER)};
    end else begin
      r = {1'b0, 1'b0, al, (t == len), 4'(n - 1)};
    end
    return r;
  endfunction

  function automatic logic [7:0] obs();
    return {busy, buzzer, src_alarm, done, beep_idx};
  endfunction

  task automatic settle_low();
    hourly_req = 1'b0;
    alarm_req  = 1'b0;
    repeat (1 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    alarm_req = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 00", obs());
    end
    clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== 8'h00) begin
        bad++;
        $display("FAIL reset_held_level cyc=%0d: got %h want 00", i, obs());
      end
    end
    settle_low();
  endtask

  task automatic test_hourly();
    int rises;
    logic prev;
    mute = 1'b0;
    rises = 0;
    prev = 1'b0;
    hourly_req = 1'b1;
    for (int t = 0; t <= NH * PER + 2; t++) begin
      @(negedge clk);
      if (t == 50) hourly_req = 1'b0;
      if (buzzer && !prev) rises++;
      prev = buzzer;
      total++;
      if (obs() !== model(t, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL hourly t=%0d: got %h want %h", t, obs(), model(t, 1'b0, 1'b0));
      end
    end
    total++;
    if (rises !== NH * 5) begin
      bad++;
      $display("FAIL hourly_rises: got %0d want %0d", rises, NH * 5);
    end
    settle_low();
  endtask

  task automatic test_alarm(input bit mu, input string name);
    int highs;
    mute = mu;
    highs = 0;
    alarm_req = 1'b1;
    for (int t = 0; t <= NA * PER + 2; t++) begin
      @(negedge clk);
      if (buzzer) highs++;
      total++;
      if (obs() !== model(t, 1'b1, mu)) begin
        bad++;
        $display("FAIL %s t=%0d: got %h want %h", name, t, obs(), model(t, 1'b1, mu));
      end
    end
    total++;
    if (highs !== (mu ? 0 : NA * 10)) begin
      bad++;
      $display("FAIL %s_high_cycles: got %0d want %0d", name, highs, mu ? 0 : NA * 10);
    end
    mute = 1'b0;
    settle_low();
  endtask

  task automatic test_preempt();
    int k, j;
    k = $urandom_range(1, NH * PER - 1);
    j = $urandom_range(0, NA * PER - 5);
    hourly_req = 1'b1;
    for (int t = 0; t <= k; t++) begin
      @(negedge clk);
      total++;
      if (obs() !== model(t, 1'b0, 1'b0)) begin
        bad++;
        $display("FAIL preempt_hourly t=%0d: got %h want %h", t, obs(), model(t, 1'b0, 1'b0));
      end
    end
    alarm_req = 1'b1;
    for (int t = 0; t <= NA * PER + 2; t++) begin
      @(negedge clk);
      total++;
      if (obs() !== model(t, 1'b1, 1'b0)) begin
        bad++;
        $display("FAIL preempt_alarm k=%0d t=%0d: got %h want %h", k, t, obs(), model(t, 1'b1, 1'b0));
      end
      if (t == j) hourly_req = 1'b0;
      if (t == j + 2) hourly_req = 1'b1;
    end
    settle_low();
  endtask

  task automatic test_stop_with_edge();
    int last;
    last = 2 * PER + $urandom_range(0, PER - 1);
    alarm_req = 1'b1;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      total++;
      if (obs() !== model(t, 1'b1, 1'b0)) begin
        bad++;
        $display("FAIL stop_run t=%0d: got %h want %h", t, obs(), model(t, 1'b1, 1'b0));
      end
      if (t == last - 1) alarm_req = 1'b0;
    end
    stop = 1'b1;
    alarm_req = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (obs() !== 8'b0010_0000) begin
      bad++;
      $display("FAIL stop_edge: got %h want 20", obs());
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== 8'b0010_0000) begin
        bad++;
        $display("FAIL stop_no_restart cyc=%0d: got %h want 20", i, obs());
      end
    end
    settle_low();
  endtask

  task automatic test_reset_mid();
    int k;
    k = $urandom_range(3, BEEP - 3);
    alarm_req = 1'b1;
    for (int t = 0; t <= k; t++) begin
      @(negedge clk);
      total++;
      if (obs() !== model(t, 1'b1, 1'b0)) begin
        bad++;
        $display("FAIL rstmid_run t=%0d: got %h want %h", t, obs(), model(t, 1'b1, 1'b0));
      end
    end
    clr = 1'b1;
    hourly_req = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (obs() !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_outputs: got %h want 00", obs());
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== 8'h00) begin
        bad++;
        $display("FAIL rstmid_idle cyc=%0d: got %h want 00", i, obs());
      end
    end
    settle_low();
  endtask

  task automatic test_back_to_back();
    bit al, mu, nal;
    int len;
    al = 1'($urandom_range(0, 1));
    mu = 1'($urandom_range(0, 1));
    mute = mu;
    if (al) alarm_req = 1'b1; else hourly_req = 1'b1;
    for (int s = 0; s < 4; s++) begin
      len = (al ? NA : NH) * PER;
      for (int t = 0; t <= len; t++) begin
        @(negedge clk);
        total++;
        if (obs() !== model(t, al, mu)) begin
          bad++;
          $display("FAIL b2b s=%0d t=%0d: got %h want %h", s, t, obs(), model(t, al, mu));
        end
        if (t == 1) begin
          alarm_req  = 1'b0;
          hourly_req = 1'b0;
        end
      end
      nal = 1'($urandom_range(0, 1));
      mu  = 1'($urandom_range(0, 1));
      mute = mu;
      al = nal;
      if (s < 3) begin
        if (al) alarm_req = 1'b1; else hourly_req = 1'b1;
      end
    end
    mute = 1'b0;
    settle_low();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hourly();
    test_alarm(1'b0, "alarm");
    test_alarm(1'b1, "alarm_mute");
    test_preempt();
    test_stop_with_edge();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
